// File: rtl/dma_axi_w_burst.sv
// dma_axi_w_burst: AXI4 write DMA that splits one command into boundary-safe INCR bursts
module dma_axi_w_burst #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int BOUNDARY  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_strb,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int XW    = (ADDR_W > LEN_W ? ADDR_W : LEN_W) + 2;

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    rem_q, rem_d, rem_nx;
    logic [8:0]        beats_q, beats_d, cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, bready_q, bready_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [XW-1:0]     room, lim_r;
    logic              in_data, last, beat;

    assign in_data       = state_q == DATA;
    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(beats_q - 9'd1);
    assign m_axi_awsize  = 3'(SZ);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_bready  = bready_q;
    // W channel is a gated pass-through of the payload stream while a burst is open
    assign m_axi_wvalid  = in_data & s_valid;
    assign m_axi_wdata   = in_data ? s_data : '0;
    assign m_axi_wstrb   = in_data ? s_strb : '0;
    assign m_axi_wlast   = in_data & last;
    assign s_ready       = in_data & m_axi_wready;

    always_comb begin
        room        = (XW'(BOUNDARY) - XW'(addr_q & ADDR_W'(BOUNDARY - 1))) >> SZ;
        lim_r       = XW'(rem_q) < XW'(MAX_BURST) ? XW'(rem_q) : XW'(MAX_BURST);
        last        = cnt_q == beats_q - 9'd1;
        beat        = in_data && s_valid && m_axi_wready;
        rem_nx      = rem_q - (LEN_W + 1)'(beats_q);
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        bready_d    = bready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d      = cmd_addr & ~ADDR_W'(BYTES - 1);
                rem_d       = {1'b0, cmd_len};
                error_d     = 1'b0;
                busy_d      = 1'b1;
                cmd_ready_d = 1'b0;
                done_d      = cmd_len == '0;
                state_d     = cmd_len == '0 ? DONE : CALC;
            end
            CALC: begin
                beats_d   = room < lim_r ? 9'(room) : 9'(lim_r);
                awvalid_d = 1'b1;
                state_d   = ADDR;
            end
            ADDR: if (m_axi_awready) begin
                awvalid_d = 1'b0;
                cnt_d     = '0;
                state_d   = DATA;
            end
            DATA: if (beat) begin
                cnt_d    = cnt_q + 9'd1;
                bready_d = last;
                state_d  = last ? RESP : DATA;
            end
            RESP: if (m_axi_bvalid) begin
                bready_d = 1'b0;
                error_d  = error_q | (m_axi_bresp != 2'b00);
                addr_d   = addr_q + (ADDR_W'(beats_q) << SZ);
                rem_d    = rem_nx;
                done_d   = rem_nx == '0;
                state_d  = rem_nx == '0 ? DONE : CALC;
            end
            DONE: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_dma_axi_w_burst.sv
// tb_dma_axi_w_burst: table-driven bench for the burst-splitting AXI write DMA
module tb_dma_axi_w_burst;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] s_data = '0;
    logic [3:0]  s_strb = '0;
    logic        busy, done, error;
    logic        awid, awlock, awvalid, awready = 1'b0;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, bresp = 2'b00;
    logic [3:0]  awcache, awqos, wstrb;
    logic        wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    dma_axi_w_burst dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
        .busy(busy), .done(done), .error(error), .m_axi_awid(awid), .m_axi_awaddr(awaddr),
        .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
    );

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      len;
        int               nb;
        logic [2:0][31:0] ea;
        logic [2:0][7:0]  el;
        bit               stall;
        int               err_b;
        bit               exp_err;
    } vec_t;

    vec_t        v[8];
    vec_t        cur;
    int          n_checks = 0, n_errors = 0, cyc = 0;
    int          aw_n, beat_n, bb, b_num, src_idx, src_len, done_cnt, acc_cyc, b_cyc, vid;
    bit          stall, mon_on, w_open, b_pend, aw_prev, aw_pend, s_hold, b_hold;
    logic [31:0] aw_paddr;
    logic [7:0]  aw_plen, cur_len;

    function automatic logic [31:0] pat(input int id, input int i);
        return {8'(id), 8'hC3, 16'(i)};
    endfunction

    function automatic logic [3:0] sstrb(input int id, input int i);
        return 4'(i * 5 + id * 3 + 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [15:0] l, input int nb,
                           input logic [31:0] a0, input logic [7:0] l0, input logic [31:0] a1,
                           input logic [7:0] l1, input logic [31:0] a2, input logic [7:0] l2,
                           input bit st, input int eb, input bit ee);
        v[i].addr    = a;
        v[i].len     = l;
        v[i].nb      = nb;
        v[i].ea      = {a2, a1, a0};
        v[i].el      = {l2, l1, l0};
        v[i].stall   = st;
        v[i].err_b   = eb;
        v[i].exp_err = ee;
    endtask

    // one clock: drive all inputs at negedge, then observe the handshakes the next posedge will take
    task automatic tick(input bit cv, input bit r);
        @(negedge clk);
        cyc++;
        if (!mon_on) begin
            s_hold = 1'b0;
            b_hold = 1'b0;
        end
        rst       = r;
        cmd_valid = cv;
        cmd_addr  = cur.addr;
        cmd_len   = cur.len;
        awready   = !stall || ($urandom_range(0, 2) == 0);
        wready    = !stall || ($urandom_range(0, 1) == 0);
        if (!s_hold) s_valid = (src_idx < src_len) && (!stall || ($urandom_range(0, 1) == 0));
        s_data = pat(vid, src_idx);
        s_strb = sstrb(vid, src_idx);
        if (!b_hold) bvalid = b_pend && (!stall || ($urandom_range(0, 1) == 0));
        bresp = (b_num == cur.err_b) ? 2'b10 : 2'b00;
        #1;
        if (mon_on) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (aw_pend) chk("aw_stable", 64'({awvalid, awaddr, awlen}), 64'({1'b1, aw_paddr, aw_plen}));
            if (awvalid && !aw_prev) chk("aw_latency", 64'(cyc), 64'(aw_n == 0 ? acc_cyc + 2 : b_cyc + 2));
            if (!w_open) chk("w_idle", 64'({wvalid, wlast, wdata, wstrb}), 64'(0));
            if (awvalid && awready) begin
                if (aw_n < cur.nb) begin
                    chk("awaddr", 64'(awaddr), 64'(cur.ea[aw_n[1:0]]));
                    chk("awlen", 64'(awlen), 64'(cur.el[aw_n[1:0]]));
                end else chk("aw_count", 64'(aw_n + 1), 64'(cur.nb));
                chk("aw_attr", 64'({awid, awsize, awburst, awlock, awcache, awprot, awqos}),
                    64'({1'b0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b010, 4'b0000}));
                cur_len = awlen;
                bb      = 0;
                w_open  = 1'b1;
                aw_n++;
            end
            if (wvalid && wready) begin
                chk("w_order", 64'({wdata, wstrb}), 64'({pat(vid, beat_n), sstrb(vid, beat_n)}));
                chk("wlast", 64'(wlast), 64'(bb == int'(cur_len)));
                beat_n++;
                bb++;
                if (wlast) begin
                    w_open = 1'b0;
                    b_pend = 1'b1;
                end
            end
            if (s_valid && s_ready) src_idx++;
            if (bvalid && bready) begin
                b_pend = 1'b0;
                b_num++;
                b_cyc  = cyc;
            end
            if (done) begin
                if (done_cnt == 0) chk("done_latency", 64'(cyc), 64'(cur.len == 0 ? acc_cyc + 1 : b_cyc + 1));
                done_cnt++;
            end
        end
        aw_pend  = awvalid && !awready;
        aw_paddr = awaddr;
        aw_plen  = awlen;
        aw_prev  = awvalid;
        s_hold   = s_valid && !s_ready;
        b_hold   = bvalid && !bready;
    endtask

    task automatic start_cmd(input vec_t c, input int id);
        cur     = c;
        vid     = id;
        stall   = c.stall;
        aw_n    = 0;
        beat_n  = 0;
        b_num   = 0;
        src_idx = 0;
        src_len = int'(c.len);
        done_cnt = 0;
        w_open  = 1'b0;
        b_pend  = 1'b0;
        tick(1'b1, 1'b0);
        chk("cmd_ready", 64'(cmd_ready), 64'(1));
    endtask

    task automatic run_vec(input int i);
        start_cmd(v[i], i + 1);
        tick(1'b0, 1'b0);
        chk("busy_on", 64'(busy), 64'(1));
        chk("err_clear", 64'(error), 64'(0));
        for (int k = 0; k < 3000 && done_cnt == 0; k++) tick(1'b0, 1'b0);
        chk("done_seen", 64'(done_cnt), 64'(1));
        tick(1'b0, 1'b0);
        chk("done_pulse", 64'(done_cnt), 64'(1));
        chk("busy_off", 64'(busy), 64'(0));
        chk("idle_ready", 64'(cmd_ready), 64'(1));
        chk("bursts", 64'(aw_n), 64'(v[i].nb));
        chk("beats", 64'(beat_n), 64'(v[i].len));
        chk("error", 64'(error), 64'(v[i].exp_err));
    endtask

    initial begin
        set_vec(0, 32'h1000, 16'd4, 1, 32'h1000, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0, 1'b0, -1, 1'b0);
        set_vec(1, 32'h0000, 16'd40, 3, 32'h0000, 8'd15, 32'h0040, 8'd15, 32'h0080, 8'd7, 1'b0, -1, 1'b0);
        set_vec(2, 32'h0FF8, 16'd8, 2, 32'h0FF8, 8'd1, 32'h1000, 8'd5, 32'h0, 8'd0, 1'b0, -1, 1'b0);
        set_vec(3, 32'h0100, 16'd37, 3, 32'h0100, 8'd15, 32'h0140, 8'd15, 32'h0180, 8'd4, 1'b1, -1, 1'b0);
        set_vec(4, 32'h2000, 16'd20, 2, 32'h2000, 8'd15, 32'h2040, 8'd3, 32'h0, 8'd0, 1'b0, 1, 1'b1);
        set_vec(5, 32'h3000, 16'd0, 0, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0, 1'b0, -1, 1'b0);
        set_vec(6, 32'h0FFF, 16'd2, 2, 32'h0FFC, 8'd0, 32'h1000, 8'd0, 32'h0, 8'd0, 1'b0, -1, 1'b0);
        set_vec(7, 32'h1FE0, 16'd20, 2, 32'h1FE0, 8'd7, 32'h2000, 8'd11, 32'h0, 8'd0, 1'b1, 0, 1'b1);
        cur    = v[0];
        mon_on = 1'b0;
        stall  = 1'b0;
        src_len = 0;
        src_idx = 0;
        b_pend = 1'b0;
        b_num  = 0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("reset_state", 64'({cmd_ready, s_ready, busy, done, error, awvalid, wvalid, wlast, bready}),
            64'(9'b100000000));
        tick(1'b0, 1'b0);
        mon_on = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(i);
        // abandon a burst mid-DATA with reset, then show a clean restart
        start_cmd(v[1], 9);
        for (int k = 0; k < 200 && beat_n < 5; k++) tick(1'b0, 1'b0);
        chk("mid_data", 64'(beat_n >= 5 && w_open), 64'(1));
        mon_on  = 1'b0;
        src_len = 0;
        b_pend  = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_mid", 64'({cmd_ready, s_ready, busy, done, error, awvalid, wvalid, wlast, bready}),
            64'(9'b100000000));
        chk("rst_wdata", 64'({wdata, wstrb}), 64'(0));
        tick(1'b0, 1'b0);
        aw_prev = 1'b0;
        mon_on  = 1'b1;
        run_vec(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
